// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2-read/1-write register file with busy scoreboard
//
// Purpose:
//   NUM_REGS x DATA_W register file with per-byte write enables, write-to-read
//   bypass, an optional hard-wired zero register (ZERO_REG) and an optional
//   registered read stage (READ_REG). A per-register busy bit is set by
//   alloc and cleared by write so decode can see pending producers.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   rd_addr1/2              read addresses
//   rd_data1/2, rd_busy1/2  read data and busy bit (bypassed, post-update view)
//   wr_en/addr/data/be      write port, wr_be[i] covers wr_data[8i+7:8i]
//   alloc_en/addr           mark a register busy
module regfile_param #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 0,
  parameter int READ_REG = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int BE_W     = DATA_W / 8;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic                wr_ok;
  logic                alloc_ok;
  logic [DATA_W-1:0]   wr_merged;

  logic [DATA_W-1:0]   byp_data1;
  logic [DATA_W-1:0]   byp_data2;
  logic                byp_busy1;
  logic                byp_busy2;

  // Writes/allocs aimed at the hard-wired zero register are dropped here so
  // that neither the array nor the scoreboard ever changes for address 0.
  always_comb begin
    wr_ok    = wr_en;
    alloc_ok = alloc_en;
    if (ZERO_REG != 0 && wr_addr == '0) begin
      wr_ok = 1'b0;
    end
    if (ZERO_REG != 0 && alloc_addr == '0) begin
      alloc_ok = 1'b0;
    end
  end

  // Byte-merge of the write data over the current register contents.
  always_comb begin
    wr_merged = regs_q[wr_addr];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) begin
        wr_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Next state of the array and scoreboard. Alloc is applied after the write
  // so that alloc wins on the busy bit when both target the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_merged;
      busy_d[wr_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Bypassed read view: the next-state array already holds the merged write
  // and the post-update busy value, so reading it gives write-to-read bypass.
  always_comb begin
    byp_data1 = regs_d[rd_addr1];
    byp_data2 = regs_d[rd_addr2];
    byp_busy1 = busy_d[rd_addr1];
    byp_busy2 = busy_d[rd_addr2];
    if (ZERO_REG != 0 && rd_addr1 == '0) begin
      byp_data1 = '0;
      byp_busy1 = 1'b0;
    end
    if (ZERO_REG != 0 && rd_addr2 == '0) begin
      byp_data2 = '0;
      byp_busy2 = 1'b0;
    end
  end

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [DATA_W-1:0] rd_data1_q;
      logic [DATA_W-1:0] rd_data2_q;
      logic              rd_busy1_q;
      logic              rd_busy2_q;
      logic [DATA_W-1:0] rd_data1_d;
      logic [DATA_W-1:0] rd_data2_d;
      logic              rd_busy1_d;
      logic              rd_busy2_d;

      always_comb begin
        rd_data1_d = byp_data1;
        rd_data2_d = byp_data2;
        rd_busy1_d = byp_busy1;
        rd_busy2_d = byp_busy2;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data1_q <= '0;
          rd_data2_q <= '0;
          rd_busy1_q <= 1'b0;
          rd_busy2_q <= 1'b0;
        end else begin
          rd_data1_q <= rd_data1_d;
          rd_data2_q <= rd_data2_d;
          rd_busy1_q <= rd_busy1_d;
          rd_busy2_q <= rd_busy2_d;
        end
      end

      assign rd_data1 = rd_data1_q;
      assign rd_data2 = rd_data2_q;
      assign rd_busy1 = rd_busy1_q;
      assign rd_busy2 = rd_busy2_q;
    end else begin : g_read_comb
      assign rd_data1 = byp_data1;
      assign rd_data2 = byp_data2;
      assign rd_busy1 = byp_busy1;
      assign rd_busy2 = byp_busy2;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (two configurations)
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_addr1, rd_addr2;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        alloc_en;
  logic [1:0]  alloc_addr;

  logic [31:0] d0_rd_data1, d0_rd_data2, d1_rd_data1, d1_rd_data2;
  logic        d0_rd_busy1, d0_rd_busy2, d1_rd_busy1, d1_rd_busy2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // dut0: plain combinational read, no zero register
  regfile_param #(.ADDR_W(2), .DATA_W(32), .ZERO_REG(0), .READ_REG(0)) dut0 (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d0_rd_data1), .rd_data2(d0_rd_data2),
    .rd_busy1(d0_rd_busy1), .rd_busy2(d0_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  // dut1: registered read with hard-wired zero register
  regfile_param #(.ADDR_W(2), .DATA_W(32), .ZERO_REG(1), .READ_REG(1)) dut1 (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_rd_data1), .rd_data2(d1_rd_data2),
    .rd_busy1(d1_rd_busy1), .rd_busy2(d1_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  // Reference model: index 0 = dut0 config, 1 = dut1 config
  logic [31:0] m_regs [2][4];
  logic        m_busy [2][4];
  logic [31:0] m_rq1, m_rq2;
  logic        m_rb1, m_rb2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(int k, logic [1:0] a);
    logic [31:0] v;
    if (k == 1 && a == 2'd0) return 32'd0;
    v = m_regs[k][a];
    if (wr_en && wr_addr == a)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
    return v;
  endfunction

  function automatic logic exp_busy(int k, logic [1:0] a);
    if (k == 1 && a == 2'd0) return 1'b0;
    if (alloc_en && alloc_addr == a) return 1'b1;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4; a++) begin
        m_regs[k][a] = 32'd0;
        m_busy[k][a] = 1'b0;
      end
    m_rq1 = 32'd0; m_rq2 = 32'd0; m_rb1 = 1'b0; m_rb2 = 1'b0;
  endtask

  task automatic check_all();
    chk("d0_data1", d0_rd_data1, exp_data(0, rd_addr1));
    chk("d0_data2", d0_rd_data2, exp_data(0, rd_addr2));
    chk("d0_busy1", {31'd0, d0_rd_busy1}, {31'd0, exp_busy(0, rd_addr1)});
    chk("d0_busy2", {31'd0, d0_rd_busy2}, {31'd0, exp_busy(0, rd_addr2)});
    chk("d1_data1", d1_rd_data1, m_rq1);
    chk("d1_data2", d1_rd_data2, m_rq2);
    chk("d1_busy1", {31'd0, d1_rd_busy1}, {31'd0, m_rb1});
    chk("d1_busy2", {31'd0, d1_rd_busy2}, {31'd0, m_rb2});
  endtask

  // Compute the post-edge model state from the current inputs, clock once,
  // then commit it. Returns at posedge + 1.
  task automatic step();
    logic [31:0] nd [2][4];
    logic        nb [2][4];
    logic [31:0] q1, q2;
    logic        b1, b2;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4; a++) begin
        nd[k][a] = exp_data(k, 2'(a));
        nb[k][a] = exp_busy(k, 2'(a));
      end
    q1 = exp_data(1, rd_addr1); q2 = exp_data(1, rd_addr2);
    b1 = exp_busy(1, rd_addr1); b2 = exp_busy(1, rd_addr2);
    @(posedge clk);
    #1;
    m_regs = nd; m_busy = nb;
    m_rq1 = q1; m_rq2 = q2; m_rb1 = b1; m_rb2 = b2;
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic ae, input logic [1:0] aa,
                       input logic [1:0] r1, input logic [1:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    alloc_en = ae; alloc_addr = aa; rd_addr1 = r1; rd_addr2 = r2;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ae;
    logic [1:0]  aa;
    logic [1:0]  r1;
    logic [1:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] wa, logic [31:0] wd, logic [3:0] be,
                              logic ae, logic [1:0] aa, logic [1:0] r1, logic [1:0] r2,
                              logic [31:0] e1, logic [31:0] e2, logic eb1, logic eb2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.ae = ae; v.aa = aa;
    v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    // Expected values for dut0 (combinational, bypassed view), applied in order
    tbl[0]  = mk(0, 0, 0,            4'hF, 0, 0, 0, 1, 0,            0,            0, 0);
    tbl[1]  = mk(1, 0, 13,           4'hF, 0, 0, 0, 1, 13,           0,            0, 0);
    tbl[2]  = mk(1, 1, 3,            4'hF, 0, 0, 0, 1, 13,           3,            0, 0);
    tbl[3]  = mk(1, 2, 453,          4'hF, 0, 0, 2, 3, 453,          0,            0, 0);
    tbl[4]  = mk(1, 3, 30,           4'hF, 0, 0, 2, 3, 453,          30,           0, 0);
    tbl[5]  = mk(0, 0, 0,            4'hF, 0, 0, 0, 1, 13,           3,            0, 0);
    tbl[6]  = mk(1, 1, 32'h11223344, 4'hF, 0, 0, 1, 1, 32'h11223344, 32'h11223344, 0, 0);
    tbl[7]  = mk(1, 1, 32'hAABBCCDD, 4'h5, 0, 0, 1, 2, 32'h11BB33DD, 453,          0, 0);
    tbl[8]  = mk(0, 0, 0,            4'hF, 0, 0, 1, 1, 32'h11BB33DD, 32'h11BB33DD, 0, 0);
    tbl[9]  = mk(0, 0, 0,            4'hF, 1, 3, 3, 2, 30,           453,          1, 0);
    tbl[10] = mk(0, 0, 0,            4'hF, 0, 0, 3, 3, 30,           30,           1, 1);
    tbl[11] = mk(1, 3, 32'h55,       4'hF, 0, 0, 3, 0, 32'h55,       13,           0, 0);
    tbl[12] = mk(1, 3, 32'h77,       4'hF, 1, 3, 3, 3, 32'h77,       32'h77,       1, 1);
    tbl[13] = mk(0, 0, 0,            4'hF, 0, 0, 3, 3, 32'h77,       32'h77,       1, 1);
    tbl[14] = mk(1, 3, 32'hFFFFFFFF, 4'h0, 0, 0, 3, 3, 32'h77,       32'h77,       0, 0);

    // Reset state on all addresses
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_addr1 = 2'(i); rd_addr2 = 2'(3 - i);
      #1;
      check_all();
    end
    @(negedge clk);
    reset = 1'b0;
    step();

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].ae, tbl[i].aa, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("tbl%0d_data1", i), d0_rd_data1, tbl[i].e1);
      chk($sformatf("tbl%0d_data2", i), d0_rd_data2, tbl[i].e2);
      chk($sformatf("tbl%0d_busy1", i), {31'd0, d0_rd_busy1}, {31'd0, tbl[i].eb1});
      chk($sformatf("tbl%0d_busy2", i), {31'd0, d0_rd_busy2}, {31'd0, tbl[i].eb2});
      check_all();
      step();
    end

    // Asynchronous reset in the middle of a cycle
    drive(1, 2, 32'hDEADBEEF, 4'hF, 0, 0, 2, 2);
    #1; check_all(); step();
    drive(0, 0, 0, 4'hF, 0, 0, 2, 2);
    #1;
    chk("pre_reset_r2", d0_rd_data1, 32'hDEADBEEF);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_r2", d0_rd_data1, 32'd0);
    chk("async_reset_d1", d1_rd_data1, 32'd0);
    model_reset();
    check_all();
    #1;
    reset = 1'b0;

    // Zero register on dut1: write and alloc to r0 dropped, r1 untouched
    drive(1, 1, 32'h0BADF00D, 4'hF, 0, 0, 0, 1);
    #1; check_all(); step();
    drive(1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 1);
    #1; check_all(); step();
    drive(0, 0, 0, 4'hF, 0, 0, 0, 1);
    #1; check_all(); step();
    chk("zero_r0_data", d1_rd_data1, 32'd0);
    chk("zero_r0_busy", {31'd0, d1_rd_busy1}, 32'd0);
    chk("zero_r1_data", d1_rd_data2, 32'h0BADF00D);
    chk("d0_r0_written", d0_rd_data1, 32'hFFFFFFFF);
    chk("d0_r0_busy", {31'd0, d0_rd_busy1}, 32'd1);

    // Registered read latency and same-cycle write capture on dut1
    drive(1, 2, 453, 4'hF, 0, 0, 0, 0);
    #1; check_all(); step();
    drive(0, 0, 0, 4'hF, 0, 0, 2, 0);
    #1;
    chk("rr_before_edge", d1_rd_data1, 32'd0);
    check_all(); step();
    chk("rr_after_edge", d1_rd_data1, 32'd453);
    drive(1, 2, 7, 4'hF, 0, 0, 2, 0);
    #1; check_all(); step();
    chk("rr_bypass_write", d1_rd_data1, 32'd7);

    // Randomised traffic against the model, with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), $urandom, 4'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom));
      #1;
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
      end
      check_all();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised multi-ported register file that generalises the team's fixed 4 x 32-bit register file. It has configurable depth and width, per-byte write enables, write-to-read bypass, an optional hard-wired zero register, and an optional registered read stage. It also keeps a per-register busy scoreboard (set on allocate, cleared on write) so the pipelined datapath can detect pending producers. It sits between decode (read/alloc) and writeback (write).

Parameters:
ADDR_W, 2, address width; NUM_REGS = 2**ADDR_W.
DATA_W, 32, register width in bits; must be a multiple of 8; BE_W = DATA_W/8.
ZERO_REG, 0, 1 = register 0 always reads 0, is never written, and is never busy.
READ_REG, 0, 0 = combinational read ports; 1 = read data and busy registered, latency 1.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
rd_addr1  input  ADDR_W  read port 1 address
rd_addr2  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  read port 1 data
rd_data2  output  DATA_W  read port 2 data
rd_busy1  output  1  scoreboard busy bit of rd_addr1
rd_busy2  output  1  scoreboard busy bit of rd_addr2
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_be  input  BE_W  byte enables; bit i covers wr_data[8i+7:8i]
alloc_en  input  1  mark a register busy (pending producer)
alloc_addr  input  ADDR_W  register to mark busy

Behaviour:
- Reset: asserting reset immediately clears every register, every busy bit and, when READ_REG=1, the rd_data/rd_busy output registers to 0. This is asynchronous and holds while reset=1. Writes and allocs are ignored during reset.
- Write: at a rising edge with wr_en=1, each byte of regs[wr_addr] with wr_be[i]=1 takes wr_data; other bytes keep their value. wr_en=1 with wr_be=0 leaves data unchanged but still clears busy.
- Scoreboard next state per register r:
  - If alloc_en && alloc_addr==r, busy becomes 1.
  - Else if wr_en && wr_addr==r, busy becomes 0.
  - Else busy holds.
  - Alloc and write to the same register in the same cycle leaves busy=1 and the data is still written.
- Bypass (both modes): a read port whose address equals wr_addr while wr_en=1 sees the merged post-write value (enabled bytes from wr_data, the rest from the array). Its busy output shows the post-update busy value from the rule above. Both read ports may hit the same register and the write simultaneously; both see the bypassed value.
- READ_REG=0: rd_data and rd_busy are combinational in rd_addr and the current write/alloc inputs.
- READ_REG=1: on each rising edge the output registers capture the bypassed value for the addresses presented in that cycle. Data is valid one cycle after the address.
- ZERO_REG=1:
  - Address 0 reads 0 with busy 0.
  - Writes and allocs to address 0 are dropped.
  - No bypass to address 0.
- Out-of-range addresses are impossible because NUM_REGS = 2**ADDR_W.
- There are no X outputs after reset deassertion.

Test Plan:
1. Assert reset, then read all 4 registers on both ports (defaults) -> every rd_data=0 and every rd_busy=0. Write 0xDEADBEEF to r2, then pulse reset mid-cycle -> r2 reads 0 immediately, without waiting for a clock edge.
2. Write 13, 3, 453, 30 to r0..r3 with wr_be=4'hF, then read r0/r1 and r2/r3 -> 13, 3, 453, 30 on the matching ports.
3. r1 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> r1 = 0x11BB33DD. With READ_REG=0 and rd_addr1=1, the same-cycle bypass shows 0x11BB33DD before the edge.
4. Scoreboard sequence:
   - alloc r3 -> rd_busy(r3)=1 next cycle.
   - Write r3 -> busy=0, shown in the same cycle via bypass.
   - Alloc and write r3 in the same cycle -> busy stays 1 and the data is updated.
5. ZERO_REG=1: write 0xFFFFFFFF to r0 and alloc r0 -> r0 reads 0 with busy 0. r1 is unaffected.
6. READ_REG=1: present rd_addr1=2 at edge N -> rd_data1=453 after edge N, not before. Write 7 to r2 in the same cycle as the read -> the registered output is 7.
